uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive side of the UART; counterpart to the transmit shift register.
- Samples an asynchronous serial line with 1 start bit, 8 data bits LSB-first, an optional parity bit and 1 stop bit.
- Presents the received byte, a sticky ready flag and error flags to the host-side logic.
- Baud timing comes from a clock-count parameter, so no external baud tick is needed.

Parameters:
- BIT_TIME, 434: clk cycles per serial bit; minimum 4; tests use 16.
- CNT_W, 16: width of the bit-time counter; must hold BIT_TIME-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- sdi  in  1  serial data in; idles high; asynchronous to clk.
- par_en  in  1  1 = frame carries a parity bit between data and stop.
- par_odd  in  1  1 = odd parity, 0 = even; ignored when par_en=0.
- rd  in  1  one-cycle read strobe from host; acknowledges the current byte.
- rx_data  out  8  last received byte.
- rx_rdy  out  1  sticky; a byte is available.
- perr  out  1  sticky; parity mismatch on the last frame.
- ferr  out  1  sticky; stop bit sampled 0 on the last frame.
- ovf  out  1  sticky; a frame completed while rx_rdy was still 1.
- busy  out  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset:
  - Sampled on the rising clk edge while reset=0.
  - rx_data=0x00, rx_rdy=0, perr=0, ferr=0, ovf=0, busy=0.
  - FSM=IDLE, counters=0, synchronizer flops=1.
  - Reset mid-frame abandons the frame; nothing is reported.
- Input conditioning:
  - sdi passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A start edge is prev=1 and cur=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - busy=0.
  - On a start edge: load bit counter = BIT_TIME/2 - 1 (integer division), go to START.
- START:
  - On counter expiry (mid start bit): if sync sdi=0, reload BIT_TIME-1 and go to DATA with bit index 0.
  - Otherwise it is a glitch: go back to IDLE with no flags changed.
- DATA:
  - At each expiry, sample the bit into shift[index]; LSB is received first.
  - After index 7: go to PARITY if par_en=1, else STOP.
  - Reload BIT_TIME-1 on every transition.
- PARITY:
  - At expiry, compute expected = XOR of the 8 data bits XOR par_odd.
  - A mismatch sets a pending parity-error bit.
- STOP:
  - At expiry (mid stop bit), complete the frame.
  - The pending framing error is set if sync sdi=0.
- Frame completion (one clk after the stop mid-sample):
  - rx_data <= shift.
  - rx_rdy <= 1.
  - perr <= pending parity error.
  - ferr <= pending framing error.
  - ovf <= 1 if rx_rdy was 1 and rd was not asserted that cycle; otherwise ovf keeps its value.
  - FSM returns to IDLE.
  - Completion is reported in IDLE, so busy is 0 on the same cycle rx_rdy rises.
- Re-arming:
  - A new start edge is accepted from IDLE only.
  - The line must be seen high before the next falling edge counts.
  - After a break (line held low), no new frame starts until sdi returns high and then falls.
- rd strobe:
  - Clears rx_rdy, perr, ferr and ovf on the next edge.
  - rx_data holds its value.
  - rd with rx_rdy=0 has no effect.
- rd in the same cycle as frame completion: completion wins.
  - rx_rdy=1, new rx_data and flags are loaded.
  - ovf is not set.
- Overrun: the new byte overwrites rx_data; the old byte is lost.
- Latency: from the falling edge on sdi to rx_rdy rising = 3 sync cycles + BIT_TIME/2 + (8 + par_en + 1)×BIT_TIME + 1 cycle.
- Tolerance: mid-bit sampling must tolerate ±4% baud mismatch at BIT_TIME=16.

Test Plan:
- Basic receive: BIT_TIME=16, par_en=0, send 0x3C (line bits 0,0,0,1,1,1,1,0,0,1) -> rx_data=0x3C, rx_rdy=1, perr=ferr=ovf=0; rd pulse -> rx_rdy=0, rx_data stays 0x3C.
- Parity: par_en=1, par_odd=0, send 0xA5 with parity bit 0 -> perr=0; resend with parity bit 1 -> perr=1, rx_data=0xA5.
- Framing: send 0x55 with stop bit 0, then hold sdi low 40 cycles -> ferr=1, rx_data=0x55; no second frame until sdi goes high and falls again.
- Overrun and priority: send 0x11 then 0x22 without rd -> rx_data=0x22, ovf=1. After rd, send 0x33 with rd pulsed on the completion cycle -> rx_rdy=1, ovf=0.
- Glitch and reset: sdi low for 4 cycles -> back to IDLE, rx_rdy=0, busy drops. Assert reset during DATA bit 3 of a frame -> all outputs 0, busy=0; the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receive side of the UART. Oversamples an asynchronous serial line and
// recovers frames of 1 start bit, 8 data bits LSB-first, an optional parity
// bit and 1 stop bit. Bit timing comes from the BIT_TIME clock-count
// parameter; every bit is sampled at its middle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset (0 = reset)
//   sdi      in   serial data, idles high, asynchronous to clk
//   par_en   in   1 = frame carries a parity bit between data and stop
//   par_odd  in   1 = odd parity, 0 = even (ignored when par_en = 0)
//   rd       in   one-cycle read strobe; acknowledges the current byte
//   rx_data  out  last received byte
//   rx_rdy   out  sticky, a byte is available
//   perr     out  sticky, parity mismatch on the last frame
//   ferr     out  sticky, stop bit sampled low on the last frame
//   ovf      out  sticky, a frame completed while rx_rdy was still set
//   busy     out  1 while the receiver FSM is not idle
//
// Handshake: the host sees rx_rdy rise for a completed frame and acknowledges
// it with a single-cycle rd pulse; rd clears rx_rdy/perr/ferr/ovf on the next
// edge and is ignored while rx_rdy is 0. A frame completing in the same cycle
// as rd takes priority and leaves rx_rdy set with ovf clear.
//
// The FSM state is held in state_q (type state_e) for observation.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned BIT_TIME = 434,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sdi,
    input  logic       par_en,
    input  logic       par_odd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_TIME / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_TIME - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_pend_q, perr_pend_d;
    logic             ferr_pend_q, ferr_pend_d;
    logic             done_q, done_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_rdy_q, rx_rdy_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic start_edge;
    logic expire;

    // sync2_q is the synchronized line; prev_q is its previous value, so a
    // start edge needs the line to have been seen high first (re-arm after
    // a break).
    assign start_edge = prev_q & ~sync2_q;
    assign expire     = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= sdi;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Receiver FSM: every state waits for the counter to expire at mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = expire ? cnt_q : cnt_q - CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = START;
                    cnt_d       = HALF_LOAD;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            START: begin
                if (expire) begin
                    if (!sync2_q) begin
                        state_d = DATA;
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                    end else begin
                        // Line back high at mid start bit: a glitch.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d[idx_q] = sync2_q;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (expire) begin
                    if (sync2_q != (^shift_q ^ par_odd)) begin
                        perr_pend_d = 1'b1;
                    end
                    cnt_d   = FULL_LOAD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    ferr_pend_d = ~sync2_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Host-side flags. Completion (done_q) is applied after the rd clear so
    // that a coincident completion wins.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;

        if (rd && rx_rdy_q) begin
            rx_rdy_d = 1'b0;
            perr_d   = 1'b0;
            ferr_d   = 1'b0;
            ovf_d    = 1'b0;
        end

        if (done_q) begin
            rx_data_d = shift_q;
            rx_rdy_d  = 1'b1;
            perr_d    = perr_pend_q;
            ferr_d    = ferr_pend_q;
            if (rx_rdy_q && !rd) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx at BIT_TIME = 16. Frames are driven bit by
// bit on sdi; a frame-level reference model predicts the host-visible flags
// and pushes them into exp_q for comparison after each frame.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sdi = 1'b1;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model of host-visible state.
  logic [7:0]  m_data = 8'h00;
  logic        m_rdy = 1'b0;
  logic        m_perr = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_ovf = 1'b0;
  logic [12:0] exp_q[$];

  uart_rx #(.BIT_TIME(BT), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .sdi     (sdi),
    .par_en  (par_en),
    .par_odd (par_odd),
    .rd      (rd),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf),
    .busy    (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers (no checking) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [12:0] snap();
    return {rx_data, rx_rdy, perr, ferr, ovf, busy};
  endfunction

  function automatic logic [12:0] model_vec();
    return {m_data, m_rdy, m_perr, m_ferr, m_ovf, 1'b0};
  endfunction

  // A completed frame, as seen by the host.
  task automatic model_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic pbit, input logic stopb, input logic rd_done);
    if (m_rdy && !rd_done) m_ovf = 1'b1;
    else if (m_rdy && rd_done) m_ovf = 1'b0;
    m_data = d;
    m_rdy  = 1'b1;
    m_perr = pe && (pbit != ((^d) ^ po));
    m_ferr = !stopb;
    exp_q.push_back(model_vec());
  endtask

  task automatic model_rd();
    if (m_rdy) begin
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Drives one frame after 4 idle-high cycles. The falling start edge lands
  // just after edge 0; by the latency rule completion is at edge
  // 3 + BT/2 + (9+par_en)*BT + 1, i.e. the 12th edge of the stop bit.
  // rd_done raises rd for exactly that completion cycle. pre/post sample
  // rx_rdy one edge before and at completion; bpost samples busy at it.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input logic rd_done, output logic pre, output logic post,
                            output logic bpost);
    logic bits[11];
    int   n;
    n = par_en ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = par_en ? pbit : stopb;
    bits[10] = stopb;
    pre = 1'b0;
    post = 1'b0;
    bpost = 1'b0;
    sdi = 1'b1;
    tick(4);
    for (int b = 0; b < n; b++) begin
      sdi = bits[b];
      for (int c = 1; c <= BT; c++) begin
        @(posedge clk);
        #1;
        if (b == n - 1) begin
          rd = rd_done && (c == 11);
          if (c == 11) pre = rx_rdy;
          if (c == 12) begin
            post = rx_rdy;
            bpost = busy;
          end
        end
      end
    end
    rd = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    tick(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b0;
    sdi = 1'b1;
    tick(3);
    got = snap();
    checks++;
    if (got !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, 13'h0);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    par_en = 1'b0;
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, pre, post, bpost);
    checks++;
    if (pre !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: rx_rdy got %b expected 0", pre);
    end
    checks++;
    if (post !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency_edge: rx_rdy got %b expected 1", post);
    end
    checks++;
    if (bpost !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: busy got %b expected 0", bpost);
    end
    got = snap();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL basic_frame: got %h expected %h", got, exp);
    end
    pulse_rd();
    model_rd();
    got = snap();
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL basic_rd_clear: got %h expected %h", got, model_vec());
    end
    // rd while nothing is pending must not change anything.
    pulse_rd();
    model_rd();
    got = snap();
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL basic_rd_idle: got %h expected %h", got, model_vec());
    end
  endtask

  task automatic test_parity();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    logic [2:0] pb;
    logic [2:0] po;
    pb = 3'b010;
    po = 3'b100;
    par_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      par_odd = po[k];
      model_frame(8'hA5, 1'b1, po[k], pb[k], 1'b1, 1'b0);
      send_frame(8'hA5, pb[k], 1'b1, 1'b0, pre, post, bpost);
      got = snap();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL parity_%0d: got %h expected %h", k, got, exp);
      end
      pulse_rd();
      model_rd();
    end
    par_en = 1'b0;
    par_odd = 1'b0;
  endtask

  task automatic test_framing();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    int busy_seen;
    model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, pre, post, bpost);
    got = snap();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL framing_frame: got %h expected %h", got, exp);
    end
    // Line held low (break): receiver must stay idle.
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL framing_break_idle: busy cycles got %0d expected 0", busy_seen);
    end
    got = snap();
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL framing_break_hold: got %h expected %h", got, model_vec());
    end
    pulse_rd();
    model_rd();
    model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, pre, post, bpost);
    got = snap();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL framing_rearm: got %h expected %h", got, exp);
    end
    pulse_rd();
    model_rd();
  endtask

  task automatic test_overrun();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    logic [7:0] d;
    logic [3:0] rdd;
    rdd = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      d = 8'h11 * (k + 1);
      if (k == 2) begin
        pulse_rd();
        model_rd();
      end
      model_frame(d, 1'b0, 1'b0, 1'b0, 1'b1, rdd[k]);
      send_frame(d, 1'b0, 1'b1, rdd[k], pre, post, bpost);
      got = snap();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL overrun_%0d: got %h expected %h", k, got, exp);
      end
    end
    pulse_rd();
    model_rd();
  endtask

  task automatic test_glitch_reset();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    logic [7:0] d;
    sdi = 1'b1;
    tick(4);
    sdi = 1'b0;
    tick(4);
    sdi = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: got %b expected 1", busy);
    end
    tick(20);
    got = snap();
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL glitch_idle: got %h expected %h", got, model_vec());
    end
    // Leave a byte pending so the reset has something to clear.
    model_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, pre, post, bpost);
    void'(exp_q.pop_front());
    d = 8'h3C;
    tick(4);
    sdi = 1'b0;
    tick(BT);
    for (int i = 0; i < 3; i++) begin
      sdi = d[i];
      tick(BT);
    end
    sdi = d[3];
    tick(BT / 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b expected 1", busy);
    end
    reset = 1'b0;
    tick(2);
    sdi = 1'b1;
    model_reset();
    got = snap();
    checks++;
    if (got !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h expected %h", got, 13'h0);
    end
    reset = 1'b1;
    tick(2);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, pre, post, bpost);
    got = snap();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_recover: got %h expected %h", got, exp);
    end
    pulse_rd();
    model_rd();
  endtask

  task automatic test_random();
    logic pre, post, bpost;
    logic [12:0] got, exp;
    logic [7:0] d;
    logic pbit, stopb, rdn;
    for (int k = 0; k < 24; k++) begin
      par_en  = 1'($urandom_range(0, 1));
      par_odd = 1'($urandom_range(0, 1));
      d       = 8'($urandom_range(0, 255));
      pbit    = (^d) ^ par_odd ^ ($urandom_range(0, 3) == 0);
      stopb   = ($urandom_range(0, 4) != 0);
      rdn     = !m_ovf && ($urandom_range(0, 3) == 0);
      model_frame(d, par_en, par_odd, pbit, stopb, rdn);
      send_frame(d, pbit, stopb, rdn, pre, post, bpost);
      got = snap();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h (d=%h pe=%b po=%b pb=%b sb=%b)",
                 k, got, exp, d, par_en, par_odd, pbit, stopb);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_rd();
        model_rd();
        got = snap();
        checks++;
        if (got !== model_vec()) begin
          errors++;
          $display("FAIL random_rd_%0d: got %h expected %h", k, got, model_vec());
        end
      end
    end
    par_en = 1'b0;
    par_odd = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch_reset();
    test_random();
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
